// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: processor port, loader port and dmem bus of the data-memory arbiter.
interface dmem_arbiter_if;
  logic        p_req;
  logic        p_wren;
  logic [11:0] p_addr;
  logic [31:0] p_data;
  logic        p_gnt;
  logic        p_rvalid;
  logic [31:0] p_q;
  logic        d_req;
  logic        d_wren;
  logic [11:0] d_addr;
  logic [31:0] d_data;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_q;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  modport slave (
    input  p_req, p_wren, p_addr, p_data, d_req, d_wren, d_addr, d_data, mem_q,
    output p_gnt, p_rvalid, p_q, d_gnt, d_rvalid, d_q, mem_address, mem_data, mem_wren
  );
  modport master (
    output p_req, p_wren, p_addr, p_data, d_req, d_wren, d_addr, d_data, mem_q,
    input  p_gnt, p_rvalid, p_q, d_gnt, d_rvalid, d_q, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between processor (P) and loader (D), steering read data back to its issuer.
module dmem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input logic          clock,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic       last_d_q, last_d_d;
  logic [3:0] starve_q, starve_d;
  logic       p_own_q, p_own_d;
  logic       d_own_q, d_own_d;
  logic       d_win;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_d_q <= 1'b1;
      starve_q <= 4'd0;
      p_own_q  <= 1'b0;
      d_own_q  <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
      starve_q <= starve_d;
      p_own_q  <= p_own_d;
      d_own_q  <= d_own_d;
    end
  end
  // D wins when alone, or on contention when it is D's turn (mode 0) or D has starved (mode 1)
  always_comb begin
    d_win     = bus.d_req && (!bus.p_req || (PRIORITY_MODE == 0 ? !last_d_q : starve_q == LIM));
    bus.p_gnt = reset && bus.p_req && !d_win;
    bus.d_gnt = reset && d_win;
  end
  always_comb begin
    last_d_d = bus.d_gnt ? 1'b1 : bus.p_gnt ? 1'b0 : last_d_q;
    starve_d = (!bus.d_req || bus.d_gnt) ? 4'd0 : starve_q == LIM ? starve_q : starve_q + 4'd1;
    p_own_d  = bus.p_gnt && !bus.p_wren;
    d_own_d  = bus.d_gnt && !bus.d_wren;
  end
  always_comb begin
    bus.mem_wren    = bus.d_gnt ? bus.d_wren : bus.p_gnt && bus.p_wren;
    bus.mem_address = bus.d_gnt ? bus.d_addr : bus.p_gnt ? bus.p_addr : 12'd0;
    bus.mem_data    = bus.d_gnt ? bus.d_data : bus.p_gnt ? bus.p_data : 32'd0;
    bus.p_rvalid    = p_own_q;
    bus.d_rvalid    = d_own_q;
    bus.p_q         = p_own_q ? bus.mem_q : 32'd0;
    bus.d_q         = d_own_q ? bus.mem_q : 32'd0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus on a round-robin and a fixed-priority arbiter, read data checked by a scoreboard monitor.
module tb_dmem_arbiter;
  logic clock = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  dmem_arbiter_if i0 ();
  dmem_arbiter_if i1 ();
  dmem_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(4)) u0 (.clock(clock), .reset(rst), .bus(i0));
  dmem_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(4)) u1 (.clock(clock), .reset(rst), .bus(i1));
  logic [31:0] m0 [4096];
  logic [31:0] m1 [4096];
  logic [31:0] sh [2][4096];
  logic [31:0] qp0 [$];
  logic [31:0] qd0 [$];
  logic [31:0] qp1 [$];
  logic [31:0] qd1 [$];
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (i0.mem_wren) m0[i0.mem_address] <= i0.mem_data;
    if (i1.mem_wren) m1[i1.mem_address] <= i1.mem_data;
    i0.mem_q <= m0[i0.mem_address];
    i1.mem_q <= m1[i1.mem_address];
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clock) begin
    if (i0.p_rvalid) begin
      if (qp0.size() == 0) chk("p0 spurious rvalid", 1, 0); else chk("p0 rdata", i0.p_q, qp0.pop_front());
    end else chk("p0 idle q", i0.p_q, 0);
    if (i0.d_rvalid) begin
      if (qd0.size() == 0) chk("d0 spurious rvalid", 1, 0); else chk("d0 rdata", i0.d_q, qd0.pop_front());
    end else chk("d0 idle q", i0.d_q, 0);
    if (i1.p_rvalid) begin
      if (qp1.size() == 0) chk("p1 spurious rvalid", 1, 0); else chk("p1 rdata", i1.p_q, qp1.pop_front());
    end else chk("p1 idle q", i1.p_q, 0);
    if (i1.d_rvalid) begin
      if (qd1.size() == 0) chk("d1 spurious rvalid", 1, 0); else chk("d1 rdata", i1.d_q, qd1.pop_front());
    end else chk("d1 idle q", i1.d_q, 0);
  end
  task automatic drv(input int k, input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                     input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd);
    if (k == 0) begin
      i0.p_req = pr; i0.p_wren = pw; i0.p_addr = pa; i0.p_data = pd;
      i0.d_req = dr; i0.d_wren = dw; i0.d_addr = da; i0.d_data = dd;
    end else begin
      i1.p_req = pr; i1.p_wren = pw; i1.p_addr = pa; i1.p_data = pd;
      i1.d_req = dr; i1.d_wren = dw; i1.d_addr = da; i1.d_data = dd;
    end
  endtask
  task automatic cyc(input int k, input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                     input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd,
                     input logic ep, input logic ed);
    logic gp, gd, mw;
    logic [11:0] ma;
    logic [31:0] md;
    drv(k, pr, pw, pa, pd, dr, dw, da, dd);
    drv(1 - k, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    if (k == 0) begin
      gp = i0.p_gnt; gd = i0.d_gnt; mw = i0.mem_wren; ma = i0.mem_address; md = i0.mem_data;
    end else begin
      gp = i1.p_gnt; gd = i1.d_gnt; mw = i1.mem_wren; ma = i1.mem_address; md = i1.mem_data;
    end
    chk($sformatf("dut%0d p_gnt", k), {31'd0, gp}, {31'd0, ep});
    chk($sformatf("dut%0d d_gnt", k), {31'd0, gd}, {31'd0, ed});
    chk($sformatf("dut%0d mem_wren", k), {31'd0, mw}, {31'd0, ep ? pw : ed ? dw : 1'b0});
    chk($sformatf("dut%0d mem_address", k), {20'd0, ma}, {20'd0, ep ? pa : ed ? da : 12'd0});
    chk($sformatf("dut%0d mem_data", k), md, ep ? pd : ed ? dd : 32'd0);
    if (ep && !pw) begin
      if (k == 0) qp0.push_back(sh[0][pa]); else qp1.push_back(sh[1][pa]);
    end
    if (ed && !dw) begin
      if (k == 0) qd0.push_back(sh[0][da]); else qd1.push_back(sh[1][da]);
    end
    if (ep && pw) sh[k][pa] = pd;
    if (ed && dw) sh[k][da] = dd;
    @(posedge clock);
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    // Reset holds grants low even with both requesting
    drv(0, 1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
    drv(1, 1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
    @(negedge clock);
    chk("rst p_gnt0", {31'd0, i0.p_gnt}, 0);
    chk("rst d_gnt0", {31'd0, i0.d_gnt}, 0);
    chk("rst p_gnt1", {31'd0, i1.p_gnt}, 0);
    chk("rst d_gnt1", {31'd0, i1.d_gnt}, 0);
    chk("rst mem_wren0", {31'd0, i0.mem_wren}, 0);
    chk("rst mem_addr0", {20'd0, i0.mem_address}, 0);
    chk("rst rvalid0", {30'd0, i0.p_rvalid, i0.d_rvalid}, 0);
    @(posedge clock);
    #1 rst = 1'b1;
    cyc(0, 1, 1, 12'h012, 32'h12345678, 1, 1, 12'h011, 32'hCAFEF00D, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 12'h011, 32'hCAFEF00D, 0, 1);
    cyc(0, 1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 12'h010, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Mode 1: P wins four contended cycles, then D is forced through
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 1, 12'h300, 32'hA5A50000, 1, 1, 12'h3F0, 32'hD0D00000, i % 5 != 4, i % 5 == 4);
    cyc(1, 0, 0, 0, 0, 1, 0, 12'h3F0, 0, 0, 1);
    cyc(1, 1, 0, 12'h300, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 12'h021, 32'h22222222, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 12'h100 + 12'(i), 32'h10000100 + i, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 12'h020, 32'h11111111, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 1, 12'h200 + 12'(i), 32'h20000200 + i, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 12'h020, 0, 0, 1);
    cyc(0, 1, 0, 12'h021, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 12'h203, 32'h20000203, 0, 1);
    // Round-robin: each side advances its address only after being granted
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 0, 12'h100 + 12'((i + 1) / 2), 0, 1, 0, 12'h200 + 12'(i / 2), 0, i % 2 == 0, i % 2 == 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 12'h100, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 12'h300, 32'h1, 1, 1, 12'h3F0, 32'h2);
    @(negedge clock);
    chk("midrd p_gnt", {31'd0, i0.p_gnt}, 1);
    #1 rst = 1'b0;
    @(posedge clock);
    #1;
    chk("midrd p_rvalid", {31'd0, i0.p_rvalid}, 0);
    rst = 1'b1;
    cyc(0, 1, 0, 12'h100, 0, 1, 0, 12'h200, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 12'h200, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 1, 12'h301, 32'hB0B0B0B0, 1, 1, 12'h3F1, 32'hC0C0C0C0, i != 4, i == 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queues drained", qp0.size() + qd0.size() + qp1.size() + qd1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem syncram between two requesters:
  - the processor data port (P);
  - a DMA/debug loader port (D), used to preload or inspect data memory.
- Issues at most one memory access per cycle and routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the processor/loader and dmem. Runs on the dmem clock domain.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between P and D; 1 = fixed priority to P with starvation guard.
- STARVE_LIMIT, 4, mode 1 only: consecutive cycles D may be denied while requesting before D is forced to win (range 1..15).

Ports:
- clock  input  1  master clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- p_req  input  1  processor access request.
- p_wren  input  1  processor write (1) / read (0); valid with p_req.
- p_addr  input  12  processor word address.
- p_data  input  32  processor write data.
- p_gnt  output  1  processor request accepted this cycle (combinational).
- p_rvalid  output  1  processor read data valid.
- p_q  output  32  processor read data.
- d_req, d_wren, d_addr, d_data  inputs  1/1/12/32  loader equivalents of the p_* inputs.
- d_gnt, d_rvalid, d_q  outputs  1/1/32  loader equivalents of the p_* outputs.
- mem_address  output  12  to dmem address.
- mem_data  output  32  to dmem data.
- mem_wren  output  1  to dmem write enable.
- mem_q  input  32  from dmem q; valid the cycle after a read is presented.

Behaviour:
- Reset (reset=0, asynchronous):
  - p_gnt=d_gnt=0, p_rvalid=d_rvalid=0, p_q=d_q=0, mem_wren=0, mem_address=0, mem_data=0.
  - Internal state: last_winner=D (so P wins the first contended cycle), starve_cnt=0, pending read dropped.
  - Grants are forced low while reset=0.
- Grant:
  - Combinational in cycle t from the requests and registered state.
  - Exactly one of p_gnt/d_gnt is high when any req is high; both are low otherwise.
  - A request is accepted iff its gnt is high.
  - A denied requester holds req/wren/addr/data stable until granted.
- Memory drive:
  - While granted, mem_address/mem_data/mem_wren mirror the winner's addr/data/wren.
  - With no grant: mem_wren=0, mem_address=0, mem_data=0.
- Round-robin (mode 0):
  - Single requester always wins.
  - Both requesting: the requester that is not last_winner wins.
  - last_winner updates only on a cycle with a grant.
- Fixed priority (mode 1):
  - P wins contention unless starve_cnt==STARVE_LIMIT; then D wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) on each cycle d_req=1 && d_gnt=0.
  - starve_cnt clears on d_gnt=1 or when d_req=0.
- Read return:
  - A read granted in cycle t sets an owner flag.
  - In cycle t+1 the owner's rvalid=1 and its q=mem_q.
  - The non-owner's q=0. Both q=0 when neither rvalid is high.
  - Writes produce no rvalid.
- Pipelining: a new grant in cycle t+1 is permitted while the read from t returns. Back-to-back reads give one rvalid per cycle, in grant order.
- Write then read to the same address on consecutive cycles returns the new data (dmem write-through not required; the write is committed on the grant edge).
- Reset asserted mid-read: rvalid for that read is never produced.

Test Plan:
1. Reset: hold reset=0 with p_req=d_req=1 -> both gnt=0, mem_wren=0, both rvalid=0. Release reset -> first cycle p_gnt=1.
2. Single writer/reader:
   - P writes 0xDEADBEEF to address 0x010 (p_gnt same cycle, mem_wren=1).
   - Next cycle P reads 0x010 -> following cycle p_rvalid=1, p_q=0xDEADBEEF, d_rvalid=0, d_q=0.
3. Round-robin contention (mode 0): P and D both read continuously for 6 cycles -> grants alternate P,D,P,D,P,D. rvalid alternates one cycle later with the correct owner data.
4. Starvation guard (mode 1, STARVE_LIMIT=4):
   - P and D request continuously -> P granted 4 cycles, then D granted on the 5th, then P again.
   - starve_cnt returns to 0 after the D grant.
5. Pipelined ownership: D reads 0x020 (preloaded 0x11111111), then P reads 0x021 (0x22222222) the next cycle -> d_rvalid/d_q=0x11111111, then p_rvalid/p_q=0x22222222 on consecutive cycles.
6. Reset mid-read: grant a P read, assert reset before the next edge -> p_rvalid stays 0. After release, last_winner=D and starve_cnt=0.
